// File: rtl/fft_result_streamer_if.sv
// Valid/ready stream carrying one FFT bin per beat, with its bin index and frame-end marker.
interface fft_result_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 5
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_real;
    logic [DATA_WIDTH-1:0] out_imag;
    logic [IDX_WIDTH-1:0]  out_index;
    logic                  out_last;

    modport master (
        output out_valid, out_real, out_imag, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_real, out_imag, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/fft_result_streamer.sv
// Snapshots one FFT result frame and drains it one bin per beat over a valid/ready stream;
// frames arriving mid-drain are dropped and counted.
//
// state | meaning
// IDLE  | no frame held, waiting for result_valid
// DRAIN | snapshot held, presenting bins to the consumer
module fft_result_streamer #(
    parameter int DATA_WIDTH  = 16,
    parameter int N_POINTS    = 32,
    parameter int BIT_REVERSE = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           result_valid,
    input  logic [N_POINTS*DATA_WIDTH-1:0] fft_real_flat,
    input  logic [N_POINTS*DATA_WIDTH-1:0] fft_imag_flat,
    fft_result_streamer_if.master          out_stream,
    output logic                           busy,
    output logic [CNT_WIDTH-1:0]           drop_count
);
    localparam int IDX_WIDTH = $clog2(N_POINTS);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [IDX_WIDTH-1:0]  cnt, cnt_nxt, bin;
    logic                  capture, drop, xfer, at_last;
    logic [DATA_WIDTH-1:0] snap_real [N_POINTS];
    logic [DATA_WIDTH-1:0] snap_imag [N_POINTS];

    function automatic logic [IDX_WIDTH-1:0] bit_rev(input logic [IDX_WIDTH-1:0] v);
        logic [IDX_WIDTH-1:0] r;
        for (int i = 0; i < IDX_WIDTH; i++) begin
            r[i] = v[IDX_WIDTH-1-i];
        end
        return r;
    endfunction

    assign bin     = (BIT_REVERSE != 0) ? bit_rev(cnt) : cnt;
    assign at_last = (state == DRAIN) && (cnt == IDX_WIDTH'(N_POINTS - 1));
    assign xfer    = (state == DRAIN) && out_stream.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (result_valid) begin
                    capture   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && at_last) begin
                    // a frame landing on the final transfer is taken back-to-back
                    cnt_nxt = '0;
                    if (result_valid) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        cnt_nxt = cnt + IDX_WIDTH'(1);
                    end
                    if (result_valid) begin
                        drop = 1'b1;
                    end
                end
            end
        endcase
    end

    // snapshot contents are don't-care after reset, so no reset branch here
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < N_POINTS; k++) begin
                snap_real[k] <= fft_real_flat[k*DATA_WIDTH +: DATA_WIDTH];
                snap_imag[k] <= fft_imag_flat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != {CNT_WIDTH{1'b1}})) begin
            drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

    // data is gated in IDLE so outputs read zero out of reset
    assign out_stream.out_valid = (state == DRAIN);
    assign out_stream.out_last  = at_last;
    assign out_stream.out_index = (state == DRAIN) ? bin : '0;
    assign out_stream.out_real  = (state == DRAIN) ? snap_real[bin] : '0;
    assign out_stream.out_imag  = (state == DRAIN) ? snap_imag[bin] : '0;
    assign busy                 = (state == DRAIN);
endmodule

// File: tb/tb_fft_result_streamer.sv
// Directed bench for fft_result_streamer: natural and bit-reversed drains, backpressure,
// dropped frames, back-to-back capture, async reset abort and counter saturation.
module tb_fft_result_streamer;
    localparam int DW = 16;
    localparam int NP = 32;
    localparam int IW = 5;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              result_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [NP*DW-1:0]  fft_real_flat = '0;
    logic [NP*DW-1:0]  fft_imag_flat = '0;
    logic              busy0, busy1;
    logic [CW-1:0]     drop0, drop1;
    logic              mon_br = 1'b0;
    int                n_cmp = 0;
    int                n_err = 0;

    fft_result_streamer_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) if0 ();
    fft_result_streamer_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) if1 ();

    assign if0.out_ready = out_ready;
    assign if1.out_ready = out_ready;

    fft_result_streamer #(.DATA_WIDTH(DW), .N_POINTS(NP), .BIT_REVERSE(0), .CNT_WIDTH(CW)) dut0 (
        .clk(clk), .reset(reset), .result_valid(result_valid),
        .fft_real_flat(fft_real_flat), .fft_imag_flat(fft_imag_flat),
        .out_stream(if0), .busy(busy0), .drop_count(drop0)
    );

    fft_result_streamer #(.DATA_WIDTH(DW), .N_POINTS(NP), .BIT_REVERSE(1), .CNT_WIDTH(CW)) dut1 (
        .clk(clk), .reset(reset), .result_valid(result_valid),
        .fft_real_flat(fft_real_flat), .fft_imag_flat(fft_imag_flat),
        .out_stream(if1), .busy(busy1), .drop_count(drop1)
    );

    logic          m_valid, m_last, m_busy;
    logic [DW-1:0] m_real, m_imag;
    logic [IW-1:0] m_index;
    logic [CW-1:0] m_drop;

    assign m_valid = mon_br ? if1.out_valid : if0.out_valid;
    assign m_last  = mon_br ? if1.out_last  : if0.out_last;
    assign m_real  = mon_br ? if1.out_real  : if0.out_real;
    assign m_imag  = mon_br ? if1.out_imag  : if0.out_imag;
    assign m_index = mon_br ? if1.out_index : if0.out_index;
    assign m_busy  = mon_br ? busy1 : busy0;
    assign m_drop  = mon_br ? drop1 : drop0;

    initial forever #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // frame 0: real = k<<8, imag = -k; frame 1: real = 0x7F00^k, imag = 0x8000|k
    function automatic logic [15:0] exp_re(input int fr, input int k);
        if (fr == 0) return 16'(k << 8);
        return 16'h7F00 ^ 16'(k);
    endfunction

    function automatic logic [15:0] exp_im(input int fr, input int k);
        if (fr == 0) return 16'(-k);
        return 16'h8000 | 16'(k);
    endfunction

    function automatic int bitrev5(input int b);
        logic [4:0] v;
        v = b[4:0];
        return int'({v[0], v[1], v[2], v[3], v[4]});
    endfunction

    task automatic load_frame(input int fr);
        for (int k = 0; k < NP; k++) begin
            fft_real_flat[k*DW +: DW] = exp_re(fr, k);
            fft_imag_flat[k*DW +: DW] = exp_im(fr, k);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        result_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(m_valid), 32'd0);
        check_val("rst_last",  32'(m_last),  32'd0);
        check_val("rst_busy",  32'(m_busy),  32'd0);
        check_val("rst_real",  32'(m_real),  32'd0);
        check_val("rst_imag",  32'(m_imag),  32'd0);
        check_val("rst_index", 32'(m_index), 32'd0);
        check_val("rst_drop",  32'(m_drop),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int fr);
        check_val("pre_valid", 32'(m_valid), 32'd0);
        load_frame(fr);
        result_valid = 1'b1;
        @(posedge clk);
        #1;
        result_valid = 1'b0;
        check_val("lat_valid", 32'(m_valid), 32'd1);
        check_val("lat_busy",  32'(m_busy),  32'd1);
    endtask

    // rmode 0: ready always 1; rmode 1: ready pattern 1,0,0,1
    task automatic run_drain(input int br, input int fr, input int rmode,
                             input int inj_beat, input int inj_fr, input int b2b);
        int  beat = 0;
        int  cyc = 0;
        int  b;
        bit  rdy;
        bit  injected = 0;
        mon_br = br[0];
        #0;
        while (beat < NP && cyc < 400) begin
            rdy = (rmode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            out_ready = rdy;
            b = (br != 0) ? bitrev5(beat) : beat;
            if (beat == inj_beat && !injected && rdy) begin
                injected = 1;
                load_frame(inj_fr);
                result_valid = 1'b1;
            end
            check_val("beat_valid", 32'(m_valid), 32'd1);
            check_val("beat_index", 32'(m_index), 32'(b));
            check_val("beat_real",  32'(m_real),  32'(exp_re(fr, b)));
            check_val("beat_imag",  32'(m_imag),  32'(exp_im(fr, b)));
            check_val("beat_last",  32'(m_last),  32'(beat == NP - 1));
            if (rdy) beat++;
            @(posedge clk);
            #1;
            result_valid = 1'b0;
            cyc++;
        end
        check_val("drain_beats", 32'(beat), 32'(NP));
        if (b2b != 0) begin
            check_val("b2b_valid", 32'(m_valid), 32'd1);
            check_val("b2b_index", 32'(m_index), 32'd0);
            check_val("b2b_real",  32'(m_real),  32'(exp_re(inj_fr, 0)));
        end else begin
            check_val("end_valid", 32'(m_valid), 32'd0);
            check_val("end_busy",  32'(m_busy),  32'd0);
            check_val("end_last",  32'(m_last),  32'd0);
        end
    endtask

    initial begin
        #1 reset = 1'b0;

        // natural order, ready held high
        apply_reset();
        out_ready = 1'b1;
        start_frame(0);
        run_drain(0, 0, 0, -1, 0, 0);

        // backpressure pattern
        start_frame(0);
        run_drain(0, 0, 1, -1, 0, 0);

        // bit-reversed order
        apply_reset();
        out_ready = 1'b1;
        start_frame(0);
        run_drain(1, 0, 0, -1, 0, 0);
        mon_br = 1'b0;

        // dropped frame mid-drain, then back-to-back on the final transfer
        apply_reset();
        out_ready = 1'b1;
        start_frame(0);
        run_drain(0, 0, 0, 10, 1, 0);
        check_val("drop_one", 32'(drop0), 32'd1);
        start_frame(0);
        run_drain(0, 0, 0, 31, 1, 1);
        check_val("b2b_drop", 32'(drop0), 32'd1);
        run_drain(0, 1, 0, -1, 0, 0);
        check_val("b2b_drop_end", 32'(drop0), 32'd1);

        // async reset mid-drain
        apply_reset();
        out_ready = 1'b1;
        start_frame(0);
        for (int i = 0; i < 12; i++) begin
            if (i == 5) result_valid = 1'b1;
            @(posedge clk);
            #1;
            result_valid = 1'b0;
        end
        check_val("abort_pre_index", 32'(if0.out_index), 32'd12);
        check_val("abort_pre_drop",  32'(drop0), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("abort_valid", 32'(if0.out_valid), 32'd0);
        check_val("abort_busy",  32'(busy0), 32'd0);
        check_val("abort_last",  32'(if0.out_last), 32'd0);
        check_val("abort_drop",  32'(drop0), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        start_frame(0);
        run_drain(0, 0, 0, -1, 0, 0);

        // drop counter saturation under stall
        apply_reset();
        out_ready = 1'b0;
        start_frame(0);
        for (int i = 0; i < 300; i++) begin
            result_valid = 1'b1;
            @(posedge clk);
            #1;
            result_valid = 1'b0;
            @(posedge clk);
            #1;
            if (i == 99)  check_val("sat_100", 32'(drop0), 32'd100);
            if (i == 254) check_val("sat_255", 32'(drop0), 32'd255);
        end
        check_val("sat_300",   32'(drop0), 32'd255);
        check_val("sat_valid", 32'(if0.out_valid), 32'd1);
        check_val("sat_index", 32'(if0.out_index), 32'd0);
        check_val("sat_real",  32'(if0.out_real),  32'(exp_re(0, 0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
